// File: rtl/int_stim_gen.sv
// Multi-channel interrupt stimulus generator. A free-running cycle counter
// drives per-channel FSMs that produce active-low interrupt pulses in
// one-shot, periodic or level-until-acknowledged modes.
module int_stim_gen #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned CH_W   = 1
) (
  input  logic                  clk_ph1,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  cfg_we,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [1:0]            cfg_sel,
  input  logic [CNT_W-1:0]      cfg_data,
  input  logic [NUM_CH-1:0]     ack,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [NUM_CH-1:0]     int_n,
  output logic [8*NUM_CH-1:0]   fire_count
);

  localparam logic [1:0] ModeOff      = 2'd0;
  localparam logic [1:0] ModePeriodic = 2'd2;
  localparam logic [1:0] ModeLevel    = 2'd3;

  localparam logic [1:0] SelStart  = 2'd0;
  localparam logic [1:0] SelLen    = 2'd1;
  localparam logic [1:0] SelPeriod = 2'd2;
  localparam logic [1:0] SelMode   = 2'd3;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  typedef enum logic [2:0] {
    StOff,
    StArmed,
    StAsserted,
    StGap,
    StDone
  } ch_state_e;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Cycle counter advances only while run is high; wraps naturally.
  always_comb begin
    cnt_d = cnt_q;
    if (run) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk_ph1 or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cycle_count = cnt_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [CNT_W-1:0] start_q, start_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] ph_q, ph_d;
    logic [1:0]       mode_q, mode_d;
    ch_state_e        state_q, state_d;
    logic             int_n_q, int_n_d;
    logic [7:0]       fire_q, fire_d;

    logic             wr;
    logic [CNT_W-1:0] len_eff;
    logic [CNT_W-1:0] len_last;
    logic [CNT_W-1:0] gap_last;
    logic             has_gap;
    logic [7:0]       fire_inc;

    // Writes to channel indices beyond NUM_CH never match any channel.
    assign wr       = cfg_we && (cfg_ch == CH_W'(k));
    assign len_eff  = (len_q == '0) ? CntOne : len_q;
    assign len_last = len_eff - CntOne;
    assign has_gap  = (period_q > len_eff);
    assign gap_last = period_q - len_eff - CntOne;
    assign fire_inc = (fire_q == 8'hFF) ? fire_q : fire_q + 8'd1;

    // Config decode and channel FSM next-state; a MODE write overrides any transition.
    always_comb begin
      start_d  = start_q;
      len_d    = len_q;
      period_d = period_q;
      mode_d   = mode_q;
      state_d  = state_q;
      ph_d     = ph_q;
      int_n_d  = int_n_q;
      fire_d   = fire_q;

      if (wr) begin
        unique case (cfg_sel)
          SelStart:  start_d  = cfg_data;
          SelLen:    len_d    = cfg_data;
          SelPeriod: period_d = cfg_data;
          SelMode:   mode_d   = cfg_data[1:0];
        endcase
      end

      if (wr && (cfg_sel == SelMode)) begin
        ph_d    = '0;
        int_n_d = 1'b1;
        state_d = (cfg_data[1:0] == ModeOff) ? StOff : StArmed;
      end else begin
        case (state_q)
          StArmed: begin
            if (run && (cnt_q == start_q)) begin
              state_d = StAsserted;
              int_n_d = 1'b0;
              ph_d    = '0;
              fire_d  = fire_inc;
            end
          end
          StAsserted: begin
            if (mode_q == ModeLevel) begin
              // Acknowledge is honoured even while frozen.
              if (ack[k]) begin
                state_d = StDone;
                int_n_d = 1'b1;
              end
            end else if (run) begin
              // >= keeps a shortened LEN from stretching the pulse to a wrap.
              if (ph_q >= len_last) begin
                if (mode_q == ModePeriodic) begin
                  if (has_gap) begin
                    state_d = StGap;
                    int_n_d = 1'b1;
                    ph_d    = '0;
                  end
                end else begin
                  state_d = StDone;
                  int_n_d = 1'b1;
                end
              end else begin
                ph_d = ph_q + CntOne;
              end
            end
          end
          StGap: begin
            if (run) begin
              if (ph_q >= gap_last) begin
                state_d = StAsserted;
                int_n_d = 1'b0;
                ph_d    = '0;
                fire_d  = fire_inc;
              end else begin
                ph_d = ph_q + CntOne;
              end
            end
          end
          default: ;
        endcase
      end
    end

    // Channel configuration and state registers.
    always_ff @(posedge clk_ph1 or posedge rst) begin
      if (rst) begin
        start_q  <= '0;
        len_q    <= '0;
        period_q <= '0;
        mode_q   <= ModeOff;
        state_q  <= StOff;
        ph_q     <= '0;
        int_n_q  <= 1'b1;
        fire_q   <= '0;
      end else begin
        start_q  <= start_d;
        len_q    <= len_d;
        period_q <= period_d;
        mode_q   <= mode_d;
        state_q  <= state_d;
        ph_q     <= ph_d;
        int_n_q  <= int_n_d;
        fire_q   <= fire_d;
      end
    end

    assign int_n[k]            = int_n_q;
    assign fire_count[8*k +: 8] = fire_q;
  end

endmodule

// File: tb/tb_int_stim_gen.sv
// Scoreboard bench for int_stim_gen: the driver queues hand-derived expected
// outputs keyed by sample index; a monitor compares them on the falling edge.
module tb_int_stim_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 2 channels, 16-bit counter, 2-bit channel select.
  logic        rst_a, run_a, we_a;
  logic [1:0]  ch_a, sel_a, ack_a;
  logic [15:0] data_a;
  logic [15:0] cnt_a;
  logic [1:0]  intn_a;
  logic [15:0] fire_a;

  int_stim_gen #(.NUM_CH(2), .CNT_W(16), .CH_W(2)) u_dut_a (
    .clk_ph1    (clk),
    .rst        (rst_a),
    .run        (run_a),
    .cfg_we     (we_a),
    .cfg_ch     (ch_a),
    .cfg_sel    (sel_a),
    .cfg_data   (data_a),
    .ack        (ack_a),
    .cycle_count(cnt_a),
    .int_n      (intn_a),
    .fire_count (fire_a)
  );

  // Instance B: 4-bit counter for wrap-around behaviour.
  logic        rst_b, run_b, we_b;
  logic        ch_b;
  logic [1:0]  sel_b, ack_b;
  logic [3:0]  data_b;
  logic [3:0]  cnt_b;
  logic [1:0]  intn_b;
  logic [15:0] fire_b;

  int_stim_gen #(.NUM_CH(2), .CNT_W(4), .CH_W(1)) u_dut_b (
    .clk_ph1    (clk),
    .rst        (rst_b),
    .run        (run_b),
    .cfg_we     (we_b),
    .cfg_ch     (ch_b),
    .cfg_sel    (sel_b),
    .cfg_data   (data_b),
    .ack        (ack_b),
    .cycle_count(cnt_b),
    .int_n      (intn_b),
    .fire_count (fire_b)
  );

  typedef struct {
    int          due;
    bit          on_b;
    string       name;
    logic [15:0] cnt;
    logic [1:0]  intn;
    logic [15:0] fire;
  } exp_t;

  exp_t sb_q[$];
  int   samp     = 0;
  int   s0       = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  // Monitor: compare every expectation that falls due at this sample.
  initial begin
    exp_t        e;
    logic [15:0] a_cnt, a_fire;
    logic [1:0]  a_intn;
    forever begin
      @(negedge clk);
      samp++;
      while (sb_q.size() > 0 && sb_q[0].due <= samp) begin
        e      = sb_q.pop_front();
        a_cnt  = e.on_b ? {12'd0, cnt_b} : cnt_a;
        a_intn = e.on_b ? intn_b : intn_a;
        a_fire = e.on_b ? fire_b : fire_a;
        n_checks++;
        if (e.due != samp || a_cnt !== e.cnt || a_intn !== e.intn || a_fire !== e.fire) begin
          n_errors++;
          $display("FAIL %s sample=%0d due=%0d: got cnt=%0d int_n=%b fire=%h, want cnt=%0d int_n=%b fire=%h",
                   e.name, samp, e.due, a_cnt, a_intn, a_fire, e.cnt, e.intn, e.fire);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expectation for the sample taken j run-steps after s0.
  task automatic push(input string name, input int j, input int cnt, input logic [1:0] intn,
                      input logic [15:0] fire, input bit on_b);
    exp_t e;
    e.due  = s0 + j + 1;
    e.on_b = on_b;
    e.name = name;
    e.cnt  = 16'(cnt);
    e.intn = intn;
    e.fire = fire;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb_q.size() > 0; i++) tick();
    if (sb_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic reset_a();
    run_a = 1'b0;
    we_a  = 1'b0;
    ack_a = 2'b00;
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    tick();
  endtask

  task automatic cfg_a(input logic [1:0] ch, input logic [1:0] sel, input logic [15:0] data);
    we_a   = 1'b1;
    ch_a   = ch;
    sel_a  = sel;
    data_a = data;
    tick();
    we_a = 1'b0;
  endtask

  initial begin
    int   c;
    bit   lo;
    logic [7:0] f;

    rst_a = 1'b1; run_a = 1'b0; we_a = 1'b0; ch_a = '0; sel_a = '0; data_a = '0; ack_a = '0;
    rst_b = 1'b1; run_b = 1'b0; we_b = 1'b0; ch_b = '0; sel_b = '0; data_b = '0; ack_b = '0;

    // Test 1: one-shot START=5 LEN=15 -> low for counts 6..20.
    reset_a();
    cfg_a(2'd0, 2'd0, 16'd5);
    cfg_a(2'd0, 2'd1, 16'd15);
    cfg_a(2'd0, 2'd3, 16'd1);
    run_a = 1'b1;
    s0 = samp;
    for (int j = 0; j < 30; j++) begin
      lo = (j >= 6 && j <= 20);
      push("t1_oneshot", j, j, {1'b1, ~lo}, {8'd0, 7'd0, (j >= 6)}, 1'b0);
    end
    for (int j = 0; j < 30; j++) tick();
    drain();

    // Test 2: periodic START=10 LEN=3 PERIOD=8 -> low 11-13, 19-21, 27-29.
    reset_a();
    cfg_a(2'd1, 2'd0, 16'd10);
    cfg_a(2'd1, 2'd1, 16'd3);
    cfg_a(2'd1, 2'd2, 16'd8);
    cfg_a(2'd1, 2'd3, 16'd2);
    run_a = 1'b1;
    s0 = samp;
    for (int j = 0; j < 34; j++) begin
      lo = 1'b0;
      f  = 8'd0;
      if (j >= 11) begin
        lo = ((j - 11) % 8) < 3;
        f  = 8'((j - 11) / 8 + 1);
      end
      push("t2_periodic", j, j, {~lo, 1'b1}, {f, 8'd0}, 1'b0);
    end
    for (int j = 0; j < 34; j++) tick();
    drain();

    // Test 3: level START=4; early and late acks ignored, ack at 20 releases.
    reset_a();
    cfg_a(2'd0, 2'd0, 16'd4);
    cfg_a(2'd0, 2'd3, 16'd3);
    run_a = 1'b1;
    s0 = samp;
    for (int j = 0; j < 36; j++) begin
      lo = (j >= 5 && j <= 20);
      push("t3_level", j, j, {1'b1, ~lo}, {8'd0, 7'd0, (j >= 5)}, 1'b0);
    end
    for (int j = 0; j < 36; j++) begin
      ack_a[0] = (j == 2 || j == 20 || j == 30);
      tick();
    end
    ack_a = 2'b00;
    drain();

    // Test 4: one-shot with run frozen for 10 edges mid-pulse.
    reset_a();
    cfg_a(2'd0, 2'd0, 16'd5);
    cfg_a(2'd0, 2'd1, 16'd15);
    cfg_a(2'd0, 2'd3, 16'd1);
    run_a = 1'b1;
    s0 = samp;
    for (int j = 0; j < 40; j++) begin
      c  = (j <= 10) ? j : ((j <= 20) ? 10 : j - 10);
      lo = (c >= 6 && c <= 20);
      push("t4_freeze", j, c, {1'b1, ~lo}, {8'd0, 7'd0, (c >= 6)}, 1'b0);
    end
    for (int j = 0; j < 40; j++) begin
      if (j == 10) run_a = 1'b0;
      if (j == 20) run_a = 1'b1;
      tick();
    end
    drain();

    // Test 5: 4-bit counter, START=2 LEN=0 armed at count 9 -> one low cycle at count 3.
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    tick();
    run_b = 1'b1;
    s0 = samp;
    for (int j = 0; j < 40; j++) begin
      lo = (j == 19);
      push("t5_wrap_len0", j, j % 16, {1'b1, ~lo}, {8'd0, 7'd0, (j >= 19)}, 1'b1);
    end
    for (int j = 0; j < 40; j++) begin
      we_b = 1'b0;
      if (j == 0) begin we_b = 1'b1; ch_b = 1'b0; sel_b = 2'd0; data_b = 4'd2; end
      if (j == 1) begin we_b = 1'b1; ch_b = 1'b0; sel_b = 2'd1; data_b = 4'd0; end
      if (j == 9) begin we_b = 1'b1; ch_b = 1'b0; sel_b = 2'd3; data_b = 4'd1; end
      tick();
    end
    we_b = 1'b0;
    drain();

    // Test 6: async reset mid-pulse, then writes to a nonexistent channel.
    reset_a();
    cfg_a(2'd0, 2'd0, 16'd5);
    cfg_a(2'd0, 2'd1, 16'd15);
    cfg_a(2'd0, 2'd3, 16'd1);
    run_a = 1'b1;
    s0 = samp;
    for (int j = 0; j < 10; j++) begin
      lo = (j >= 6);
      push("t6_pre_rst", j, j, {1'b1, ~lo}, {8'd0, 7'd0, (j >= 6)}, 1'b0);
    end
    for (int j = 0; j < 10; j++) tick();
    rst_a = 1'b1;
    push("t6_async_rst", 10, 0, 2'b11, 16'd0, 1'b0);
    tick();
    rst_a = 1'b0;
    run_a = 1'b0;
    cfg_a(2'd3, 2'd3, 16'd1);
    cfg_a(2'd3, 2'd0, 16'd0);
    run_a = 1'b1;
    s0 = samp;
    for (int j = 0; j < 20; j++) push("t6_bad_ch", j, j, 2'b11, 16'd0, 1'b0);
    for (int j = 0; j < 20; j++) tick();
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/int_stim_gen.md
Name: int_stim_gen

Overview:
- Parametrised, multi-channel interrupt stimulus generator for CPU benches and on-board debug.
- Drives active-low interrupt lines (nmi/irq style) from a free-running cycle counter.
- Each channel is programmed at run time with start cycle, length, period and mode.
- Modes: one-shot window, periodic pulse train, level-held-until-acknowledged. Replaces hard-coded cycle-window interrupt stimulus.

Parameters:
NUM_CH, 2, number of independent interrupt channels (1..8)
CNT_W, 16, width of cycle counter and all timing registers
CH_W, 1, width of cfg_ch; must be >= ceil(log2(NUM_CH)), minimum 1

Ports:
clk_ph1  in  1  single clock; all state changes on rising edge
rst  in  1  asynchronous reset, active-high
run  in  1  1 = counters advance; 0 = freeze all counters and channel state
cfg_we  in  1  config write strobe
cfg_ch  in  CH_W  channel index for write; values >= NUM_CH ignored
cfg_sel  in  2  register select: 0 START, 1 LEN, 2 PERIOD, 3 MODE
cfg_data  in  CNT_W  write data; MODE uses bits [1:0]
ack  in  NUM_CH  per-channel acknowledge (LEVEL mode only)
cycle_count  out  CNT_W  free-running cycle counter
int_n  out  NUM_CH  interrupt lines, active-low, registered
fire_count  out  8*NUM_CH  per-channel assertion count, channel k at [8k+7:8k]

Behaviour:
- Reset (async, immediate): cycle_count=0, int_n all 1, fire_count 0, START/LEN/PERIOD 0, MODE=OFF, every channel in state OFF.
- cycle_count: +1 per edge while run=1. Wraps from 2^CNT_W-1 to 0.
- MODE encoding: 0 OFF, 1 ONESHOT, 2 PERIODIC, 3 LEVEL.
- Per-channel FSM states: OFF, ARMED, ASSERTED, GAP, DONE. Also a phase counter ph (CNT_W).
- MODE write:
  - Non-OFF value -> ARMED, ph=0, int_n=1 on the next edge.
  - OFF value -> state OFF, int_n=1.
  - Takes priority over any FSM transition in the same cycle.
- START/LEN/PERIOD writes never change state. New values are used from the next cycle.
- Effective length: LEN=0 is treated as 1.
- All transitions below occur only on edges with run=1. With run=0, state, ph and int_n hold.
- ARMED: on the edge where cycle_count==START -> ASSERTED, int_n=0, ph=0, fire_count+1.
  - int_n is therefore first low while cycle_count reads START+1.
  - If cycle_count has already passed START, the channel waits for wrap-around.
- ASSERTED, ONESHOT: ph+1 per edge. On the edge where ph==LEN_eff-1 -> DONE, int_n=1. Low time is exactly LEN_eff cycles.
- ASSERTED, PERIODIC: low for LEN_eff cycles.
  - If PERIOD > LEN_eff -> GAP, int_n=1, for PERIOD-LEN_eff cycles, then -> ASSERTED, int_n=0, fire_count+1.
  - Repeats indefinitely.
  - If PERIOD <= LEN_eff, stays in ASSERTED; int_n stays low continuously; fire_count increments once only.
- ASSERTED, LEVEL: int_n held 0 until ack[ch]=1 is sampled on an edge -> DONE, int_n=1 from that edge.
  - ack is ignored in all other states and modes.
  - ack is sampled regardless of run.
- DONE: int_n=1. Leaves only on a MODE write or reset.
- fire_count saturates at 255.
- Channels are fully independent. Simultaneous writes are impossible (one cfg port). Multiple channels may assert on the same edge.
- cfg_ch >= NUM_CH: write discarded, no side effects.
- rst asserted mid-pulse: int_n returns to 1 asynchronously. Config is lost; the channel must be re-programmed.

Test Plan:
1. NUM_CH=2, ch0 START=5 LEN=15 ONESHOT, run=1 -> int_n[0]=0 while cycle_count is 6..20, 1 from 21; fire_count[7:0]=1; int_n[1] stays 1.
2. ch1 START=10 LEN=3 PERIOD=8 PERIODIC -> int_n[1] low at counts 11-13, 19-21, 27-29; fire_count[15:8]=3 at count 30.
3. ch0 LEVEL START=4, ack pulsed at count 20 -> int_n[0] low 5..20, high from 21. A second ack pulse at 30 has no effect; an ack pulse before count 4 is ignored.
4. run toggled 0 for 10 cycles mid-pulse of test 1 -> cycle_count frozen, int_n[0] stays 0, total low time still 15 run-cycles.
5. CNT_W=4, START=2, programmed at count 9 -> first assertion after wrap, int_n low while count reads 3; LEN=0 gives exactly 1 low cycle.
6. rst pulsed while int_n[0]=0 -> int_n=all 1 and cycle_count=0 before the next edge; MODE write to cfg_ch=3 with NUM_CH=2 changes nothing.
